pdm_seq_ctrl: RTL and testbench

//  Sequencer for the 5-bit PDM modulator. Plays a small programmable table of density

---
 rtl/pdm_seq_pkg.sv | 18 +
 rtl/pdm_seq_table.sv | 32 +++
 rtl/pdm_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pdm_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_seq_pkg.sv
// pdm_seq_pkg: shared definitions for the PDM level sequencer.
//   - state_t   : sequencer FSM states
//   - DEF_*     : default level width, table depth and hold-counter width
package pdm_seq_pkg;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_HOLD_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RAMP = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pdm_seq_table.sv
// pdm_seq_table: DEPTH x WIDTH level table.
//   clk    in  : clock
//   we     in  : write strobe
//   waddr  in  : write address
//   wdata  in  : write data
//   raddr  in  : read address
//   rdata  out : asynchronous read data (old contents during a same-cycle write)
// Contents are deliberately not reset.
module pdm_seq_table #(
  parameter int   WIDTH = 5,
  parameter int   DEPTH = 8,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pdm_seq_ctrl.sv
// pdm_seq_ctrl: plays a programmable table of PDM density levels into the
// modulator, holding each level for max(hold_cycles,1) clocks, one-shot or looped.
//   clk, reset(active-low, async)
//   cfg_we/cfg_addr/cfg_data : table write port, usable in any state
//   seq_len/hold_cycles/loop_en : playback config, sampled in LOAD
//   start/stop               : playback control pulses (stop wins)
//   pdm_level/pdm_write_en   : level and 1-cycle load strobe to the modulator
//   busy                     : high outside IDLE
//   done                     : 1-cycle pulse at the end of one-shot playback
// Build option: define PDM_SEQ_RAMP_EN to step the level by +/-1 per clock
// towards each new target (and down to 0 on stop) instead of jumping.
module pdm_seq_ctrl
  import pdm_seq_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  HOLD_W = DEF_HOLD_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic [AW-1:0]     seq_len,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [WIDTH-1:0]  pdm_level,
  output logic              pdm_write_en,
  output logic              busy,
  output logic              done
);

  state_t            state_reg;
  logic [AW-1:0]     idx_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [AW-1:0]     len_reg;
  logic              loop_reg;
  logic [HOLD_W-1:0] hold_m1_reg;
  logic [WIDTH-1:0]  tbl_q;

  pdm_seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_reg),
    .rdata (tbl_q)
  );

  // Config is live in LOAD (it is being sampled that cycle), latched afterwards.
  logic [HOLD_W-1:0] hold_m1_in;
  logic [HOLD_W-1:0] hold_now;
  logic [AW-1:0]     len_now;
  logic              loop_now;
  state_t            adv_state;
  logic [AW-1:0]     adv_idx;

  assign hold_m1_in = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;

  always_comb begin
    hold_now = hold_m1_reg;
    len_now  = len_reg;
    loop_now = loop_reg;
    if (state_reg == LOAD) begin
      hold_now = hold_m1_in;
      len_now  = seq_len;
      loop_now = loop_en;
    end
  end

  // Where playback goes once the current entry's hold time is spent.
  always_comb begin
    adv_state = LOAD;
    adv_idx   = idx_reg + 1'b1;
    if (idx_reg == len_now) begin
      if (loop_now) begin
        adv_idx = '0;
      end else begin
        adv_state = DONE;
        adv_idx   = idx_reg;
      end
    end
  end

  logic stop_hit;
`ifdef PDM_SEQ_RAMP_EN
  logic [WIDTH-1:0] target_reg;
  logic             mute_reg;
  logic [WIDTH-1:0] ramp_tgt;
  logic [WIDTH-1:0] step_level;

  assign ramp_tgt   = (state_reg == LOAD) ? tbl_q : target_reg;
  assign step_level = (pdm_level < ramp_tgt) ? pdm_level + 1'b1 : pdm_level - 1'b1;
  // A mute ramp already in progress is not restarted by another stop.
  assign stop_hit   = stop && (state_reg != IDLE) && !mute_reg;
`else
  assign stop_hit   = stop && (state_reg != IDLE);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      hold_cnt_reg <= '0;
      len_reg      <= '0;
      loop_reg     <= 1'b0;
      hold_m1_reg  <= '0;
      pdm_level    <= '0;
      pdm_write_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef PDM_SEQ_RAMP_EN
      target_reg   <= '0;
      mute_reg     <= 1'b0;
`endif
    end else begin
      pdm_write_en <= 1'b0;
      done         <= 1'b0;
      if (stop_hit) begin
        pdm_write_en <= 1'b1;
`ifdef PDM_SEQ_RAMP_EN
        if (pdm_level > WIDTH'(1)) begin
          pdm_level <= pdm_level - 1'b1;
          mute_reg  <= 1'b1;
          state_reg <= RAMP;
        end else begin
          pdm_level <= '0;
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
`else
        pdm_level <= '0;
        state_reg <= IDLE;
        busy      <= 1'b0;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !stop) begin
              state_reg <= LOAD;
              idx_reg   <= '0;
              busy      <= 1'b1;
            end
          end
          LOAD: begin
            len_reg      <= seq_len;
            loop_reg     <= loop_en;
            hold_m1_reg  <= hold_m1_in;
            pdm_write_en <= 1'b1;
`ifdef PDM_SEQ_RAMP_EN
            target_reg <= tbl_q;
            if (tbl_q != pdm_level && step_level != tbl_q) begin
              pdm_level <= step_level;
              state_reg <= RAMP;
            end else begin
              pdm_level    <= tbl_q;
              hold_cnt_reg <= hold_now;
              if (hold_now == '0) begin
                state_reg <= adv_state;
                idx_reg   <= adv_idx;
              end else begin
                state_reg <= HOLD;
              end
            end
`else
            pdm_level    <= tbl_q;
            // A one-clock hold skips HOLD entirely so writes land every clock.
            hold_cnt_reg <= hold_now;
            if (hold_now == '0) begin
              state_reg <= adv_state;
              idx_reg   <= adv_idx;
            end else begin
              state_reg <= HOLD;
            end
`endif
          end
`ifdef PDM_SEQ_RAMP_EN
          RAMP: begin
            pdm_write_en <= 1'b1;
            pdm_level    <= step_level;
            if (mute_reg) begin
              if (step_level == '0) begin
                mute_reg  <= 1'b0;
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end else if (step_level == target_reg) begin
              // Hold time counts from the write that reaches the target.
              hold_cnt_reg <= hold_now;
              if (hold_now == '0) begin
                state_reg <= adv_state;
                idx_reg   <= adv_idx;
              end else begin
                state_reg <= HOLD;
              end
            end
          end
`endif
          HOLD: begin
            hold_cnt_reg <= hold_cnt_reg - 1'b1;
            if (hold_cnt_reg == HOLD_W'(1)) begin
              state_reg <= adv_state;
              idx_reg   <= adv_idx;
            end
          end
          DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdm_seq_ctrl.sv
// Directed bench for pdm_seq_ctrl: table of playback vectors plus hand-written
// sequences for loop/stop, reset, start/stop interaction and table rewrites.
module tb_pdm_seq_ctrl;
  import pdm_seq_pkg::*;

  localparam int AW = $clog2(DEF_DEPTH);
`ifdef PDM_SEQ_RAMP_EN
  localparam bit RAMP_MODE = 1'b1;
`else
  localparam bit RAMP_MODE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [AW-1:0]         cfg_addr = '0;
  logic [DEF_WIDTH-1:0]  cfg_data = '0;
  logic [AW-1:0]         seq_len = '0;
  logic [DEF_HOLD_W-1:0] hold_cycles = '0;
  logic                  loop_en = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [DEF_WIDTH-1:0]  pdm_level;
  logic                  pdm_write_en;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  pdm_seq_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .seq_len(seq_len), .hold_cycles(hold_cycles), .loop_en(loop_en), .start(start), .stop(stop),
    .pdm_level(pdm_level), .pdm_write_en(pdm_write_en), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Log of observed write strobes and done pulses, sampled on the falling edge.
  int wr_cyc[$];
  int wr_lvl[$];
  int done_cyc[$];
  always @(negedge clk) begin
    if (pdm_write_en) begin
      wr_cyc.push_back(cyc);
      wr_lvl.push_back(int'(pdm_level));
    end
    if (done) done_cyc.push_back(cyc);
  end

  // Bench model: table copy, current level, expected write stream.
  int model_tbl[8];
  int model_level = 0;
  int exp_lvl[$];
  int exp_dt[$];   // clocks since previous write; 0 = not checked

  typedef struct {
    string name;
    int    len;
    int    hold;
    int    exp_gap;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_lvl.delete(); done_cyc.delete();
    exp_lvl.delete(); exp_dt.delete();
  endtask

  task automatic tbl_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = DEF_WIDTH'(data);
    tick(1);
    cfg_we = 1'b0;
    model_tbl[addr] = data;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic emit_entry(input int tgt, input int gap, input bit first);
    int dt;
    dt = first ? 0 : gap;
    if (!RAMP_MODE || model_level == tgt) begin
      exp_lvl.push_back(tgt); exp_dt.push_back(dt);
    end else begin
      while (model_level != tgt) begin
        model_level += (tgt > model_level) ? 1 : -1;
        exp_lvl.push_back(model_level); exp_dt.push_back(dt);
        dt = 1;
      end
    end
    model_level = tgt;
  endtask

  task automatic emit_mute();
    int dt;
    dt = 0;
    if (RAMP_MODE && model_level > 0) begin
      while (model_level > 0) begin
        model_level--;
        exp_lvl.push_back(model_level); exp_dt.push_back(dt);
        dt = 1;
      end
    end else begin
      exp_lvl.push_back(0); exp_dt.push_back(0);
      model_level = 0;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin tick(1); n++; end
    check({tag, " busy_low"}, int'(busy), 0);
    tick(2);
  endtask

  task automatic wait_writes(input string tag, input int count, input int limit);
    int n;
    n = 0;
    while (wr_lvl.size() < count && n < limit) begin tick(1); n++; end
    check({tag, " write_count_reached"}, int'(wr_lvl.size() >= count), 1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " writes"}, wr_lvl.size(), exp_lvl.size());
    for (int i = 0; i < exp_lvl.size() && i < wr_lvl.size(); i++) begin
      check($sformatf("%s level[%0d]", tag, i), wr_lvl[i], exp_lvl[i]);
      if (i > 0 && exp_dt[i] > 0)
        check($sformatf("%s spacing[%0d]", tag, i), wr_cyc[i] - wr_cyc[i-1], exp_dt[i]);
    end
  endtask

  task automatic play_once(input string tag, input int len, input int hold, input int gap);
    clear_logs();
    seq_len = AW'(len); hold_cycles = DEF_HOLD_W'(hold); loop_en = 1'b0;
    for (int i = 0; i <= len; i++) emit_entry(model_tbl[i], gap, i == 0);
    pulse_start();
    wait_idle(tag, 3000);
    compare_stream(tag);
    check({tag, " done_pulses"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0)
      check({tag, " done_delay"}, done_cyc[0] - wr_cyc[wr_cyc.size()-1], gap);
    $display("playback %s: len=%0d hold=%0d writes=%0d done=%0d", tag, len, hold,
             wr_lvl.size(), done_cyc.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_level;
    int n;

    vecs[0] = '{"t1_len3_hold64", 3, 64, 64};
    vecs[1] = '{"len1_hold0",     1, 0,  1};
    vecs[2] = '{"len1_hold1",     1, 1,  1};
    vecs[3] = '{"len0_hold5",     0, 5,  5};
    vecs[4] = '{"len7_hold2",     7, 2,  2};
    vecs[5] = '{"len2_hold255",   2, 255, 255};

    // Reset state.
    tick(3);
    check("reset pdm_level", int'(pdm_level), 0);
    check("reset write_en", int'(pdm_write_en), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    reset = 1'b1;
    tick(2);
    $display("reset released");

    tbl_write(0, 'h08); tbl_write(1, 'h1a); tbl_write(2, 'h0f); tbl_write(3, 'h04);
    tbl_write(4, 'h11); tbl_write(5, 'h1f); tbl_write(6, 'h00); tbl_write(7, 'h03);

    foreach (vecs[v]) play_once(vecs[v].name, vecs[v].len, vecs[v].hold, vecs[v].exp_gap);

    // Looped playback then stop-mute.
    clear_logs();
    seq_len = 3; hold_cycles = 64; loop_en = 1'b1;
    for (int i = 0; i < 4; i++) emit_entry(model_tbl[i], 64, i == 0);
    emit_entry(model_tbl[0], 64, 1'b0);
    pulse_start();
    wait_writes("loop", exp_lvl.size(), 2000);
    tick(5);
    compare_stream("loop");
    check("loop busy", int'(busy), 1);
    check("loop no_done", done_cyc.size(), 0);
    $display("playback loop: writes=%0d", wr_lvl.size());
    clear_logs();
    emit_mute();
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("stop", 100);
    compare_stream("stop");
    check("stop no_done", done_cyc.size(), 0);
    $display("stop mute: writes=%0d", wr_lvl.size());

    // start+stop together in IDLE does nothing.
    clear_logs();
    loop_en = 1'b0;
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    tick(4);
    check("start_stop busy", int'(busy), 0);
    check("start_stop writes", wr_lvl.size(), 0);
    $display("start+stop in idle: writes=%0d", wr_lvl.size());

    // Rewrite idx 2 while idx 1 is held; second start while busy is ignored.
    clear_logs();
    saved_level = model_level;
    seq_len = 3; hold_cycles = 64; loop_en = 1'b0;
    pulse_start();
    n = 0;
    while (!(wr_lvl.size() > 0 && wr_lvl[wr_lvl.size()-1] == 'h1a) && n < 500) begin tick(1); n++; end
    check("rewrite reached_idx1", int'(n < 500), 1);
    tbl_write(2, 'h15);
    tick(3);
    pulse_start();
    model_level = saved_level;
    for (int i = 0; i < 4; i++) emit_entry(model_tbl[i], 64, i == 0);
    wait_idle("rewrite", 1000);
    compare_stream("rewrite");
    check("rewrite done_pulses", done_cyc.size(), 1);
    $display("rewrite during hold: writes=%0d", wr_lvl.size());

    // Asynchronous reset mid-HOLD, then replay with the table intact.
    clear_logs();
    pulse_start();
    tick(10);
    #2 reset = 1'b0;
    #1;
    check("async_reset pdm_level", int'(pdm_level), 0);
    check("async_reset write_en", int'(pdm_write_en), 0);
    check("async_reset busy", int'(busy), 0);
    check("async_reset done", int'(done), 0);
    tick(2);
    reset = 1'b1;
    model_level = 0;
    tick(1);
    $display("async reset applied mid-hold");
    play_once("after_reset", 3, 64, 64);

`ifdef PDM_SEQ_RAMP_EN
    // Level 04 -> 08 ramps 05,06,07,08 on consecutive clocks, then holds 64.
    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    model_level = 0;
    tbl_write(0, 'h04); tbl_write(1, 'h08);
    play_once("ramp", 1, 64, 64);
    if (wr_lvl.size() == 8) begin
      for (int i = 4; i < 8; i++) check($sformatf("ramp step[%0d]", i), wr_lvl[i], i + 1);
      check("ramp hold_before_step", wr_cyc[4] - wr_cyc[3], 64);
      for (int i = 5; i < 8; i++) check($sformatf("ramp consecutive[%0d]", i), wr_cyc[i] - wr_cyc[i-1], 1);
    end else begin
      check("ramp write_total", wr_lvl.size(), 8);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
